// File: rtl/fourstate_deser_reduce_pkg.sv
// Shared types, symbol constants and 4-state reduction step functions
// for the 4-state symbol stream.
package fourstate_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_0 = 2'b00;
  localparam sym_t SYM_1 = 2'b01;
  localparam sym_t SYM_X = 2'b10;
  localparam sym_t SYM_Z = 2'b11;

  typedef enum logic {
    COLLECT,
    FULL
  } deser_state_t;

  // z is folded onto x before any reduction step
  function automatic sym_t sym_norm(input sym_t s);
    return (s == SYM_Z) ? SYM_X : s;
  endfunction

  function automatic sym_t red_and_step(input sym_t acc, input sym_t sym);
    sym_t a;
    sym_t s;
    a = sym_norm(acc);
    s = sym_norm(sym);
    if (a == SYM_0 || s == SYM_0) return SYM_0;
    if (a[1] || s[1])             return SYM_X;
    return SYM_1;
  endfunction

  function automatic sym_t red_or_step(input sym_t acc, input sym_t sym);
    sym_t a;
    sym_t s;
    a = sym_norm(acc);
    s = sym_norm(sym);
    if (a == SYM_1 || s == SYM_1) return SYM_1;
    if (a[1] || s[1])             return SYM_X;
    return SYM_0;
  endfunction

  function automatic sym_t red_xor_step(input sym_t acc, input sym_t sym);
    sym_t a;
    sym_t s;
    a = sym_norm(acc);
    s = sym_norm(sym);
    if (a[1] || s[1]) return SYM_X;
    return {1'b0, a[0] ^ s[0]};
  endfunction

endpackage

// File: rtl/fourstate_deser_reduce_if.sv
// Symbol-in / word-out handshake bundle for fourstate_deser_reduce.
interface fourstate_deser_reduce_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [WIDTH-1:0] out_unk;
  logic [1:0]       out_and;
  logic [1:0]       out_or;
  logic [1:0]       out_xor;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_val, out_unk, out_and, out_or, out_xor
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_val, out_unk, out_and, out_or, out_xor
  );
endinterface

// File: rtl/fourstate_red_acc.sv
// Incremental 4-state &, | and ^ accumulators; seed restarts from one symbol.
module fourstate_red_acc
  import fourstate_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic seed,
  input  logic en,
  input  sym_t sym,
  output sym_t red_and,
  output sym_t red_or,
  output sym_t red_xor
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_and <= SYM_1;
      red_or  <= SYM_0;
      red_xor <= SYM_0;
    end else if (clear) begin
      red_and <= SYM_1;
      red_or  <= SYM_0;
      red_xor <= SYM_0;
    end else if (seed) begin
      red_and <= red_and_step(SYM_1, sym);
      red_or  <= red_or_step(SYM_0, sym);
      red_xor <= red_xor_step(SYM_0, sym);
    end else if (en) begin
      red_and <= red_and_step(red_and, sym);
      red_or  <= red_or_step(red_or, sym);
      red_xor <= red_xor_step(red_xor, sym);
    end
  end

endmodule

// File: rtl/fourstate_deser_reduce.sv
// Bit-serial 4-state word receiver: MSB-first symbols into value/unknown
// planes, with running reductions and a valid/ready word output.
module fourstate_deser_reduce
  import fourstate_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  fourstate_deser_reduce_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  deser_state_t     state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pos;
  logic             valid_q;
  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] unk_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             acc_clear;
  logic             acc_seed;
  logic             acc_en;

  // only combinational path: out_ready -> in_ready while a word is held
  assign bus.in_ready = (state == COLLECT) || bus.out_ready;
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = valid_q && bus.out_ready;
  assign pos          = CNT_W'(WIDTH - 1) - count;

  assign acc_en    = in_xfer && (state == COLLECT);
  assign acc_seed  = out_xfer && in_xfer;
  assign acc_clear = out_xfer && !in_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      count   <= '0;
      valid_q <= 1'b0;
      val_q   <= '0;
      unk_q   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_xfer) begin
            val_q[pos] <= bus.in_code[0];
            unk_q[pos] <= bus.in_code[1];
            if (count == CNT_W'(WIDTH - 1)) begin
              count   <= '0;
              state   <= FULL;
              valid_q <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FULL: begin
          if (out_xfer) begin
            state   <= COLLECT;
            valid_q <= 1'b0;
            // a symbol accepted alongside the hand-off starts the next word
            if (in_xfer) begin
              val_q[WIDTH-1] <= bus.in_code[0];
              unk_q[WIDTH-1] <= bus.in_code[1];
              count          <= CNT_W'(1);
            end else begin
              count <= '0;
            end
          end
        end
        default: begin
          state   <= COLLECT;
          count   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  fourstate_red_acc u_red_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (acc_clear),
    .seed    (acc_seed),
    .en      (acc_en),
    .sym     (bus.in_code),
    .red_and (bus.out_and),
    .red_or  (bus.out_or),
    .red_xor (bus.out_xor)
  );

  assign bus.out_valid = valid_q;
  assign bus.out_val   = val_q;
  assign bus.out_unk   = unk_q;

endmodule

// File: tb/tb_fourstate_deser_reduce.sv
// Randomised and directed bench for fourstate_deser_reduce against a
// symbol-list reference model of the word and its 4-state reductions.
module tb_fourstate_deser_reduce;

  localparam int unsigned WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fourstate_deser_reduce_if #(.WIDTH(WIDTH)) bus ();

  fourstate_deser_reduce #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: symbols of the word in progress, and the held word
  logic [1:0]       cur[$];
  logic             mvalid;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] eu;
  logic [1:0]       ea;
  logic [1:0]       eo;
  logic [1:0]       ex;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    cur.delete();
    mvalid = 1'b0;
  endfunction

  // word and reductions straight from the symbol list
  function automatic void model_complete();
    bit any0, any1, anyu, par;
    any0 = 0; any1 = 0; anyu = 0; par = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      ev[WIDTH-1-i] = cur[i][0];
      eu[WIDTH-1-i] = cur[i][1];
      if (cur[i] == 2'b00) any0 = 1;
      if (cur[i] == 2'b01) any1 = 1;
      if (cur[i][1])       anyu = 1;
      else                 par  = par ^ cur[i][0];
    end
    ea = any0 ? 2'b00 : (anyu ? 2'b10 : 2'b01);
    eo = any1 ? 2'b01 : (anyu ? 2'b10 : 2'b00);
    ex = anyu ? 2'b10 : {1'b0, par};
    cur.delete();
    mvalid = 1'b1;
  endfunction

  // one clock: check held outputs, drive inputs, check in_ready, advance model
  task automatic cycle(input logic v, input logic [1:0] c, input logic r);
    logic in_x, out_x;
    chk("out_valid", 64'(bus.out_valid), 64'(mvalid));
    if (mvalid) begin
      chk("out_val", 64'(bus.out_val), 64'(ev));
      chk("out_unk", 64'(bus.out_unk), 64'(eu));
      chk("out_and", 64'(bus.out_and), 64'(ea));
      chk("out_or",  64'(bus.out_or),  64'(eo));
      chk("out_xor", 64'(bus.out_xor), 64'(ex));
    end
    bus.in_valid  = v;
    bus.in_code   = c;
    bus.out_ready = r;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(!mvalid || r));
    out_x = mvalid && r;
    in_x  = v && (!mvalid || r);
    if (out_x) mvalid = 1'b0;
    if (in_x) begin
      cur.push_back(c);
      if (cur.size() == WIDTH) model_complete();
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [1:0] s0, input logic [1:0] s1,
                           input logic [1:0] s2, input logic [1:0] s3);
    cycle(1'b1, s0, 1'b1);
    cycle(1'b1, s1, 1'b1);
    cycle(1'b1, s2, 1'b1);
    cycle(1'b1, s3, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_val"},   64'(bus.out_val),   64'(0));
    chk({tag, "_unk"},   64'(bus.out_unk),   64'(0));
    chk({tag, "_and"},   64'(bus.out_and),   64'(2'b01));
    chk({tag, "_or"},    64'(bus.out_or),    64'(2'b00));
    chk({tag, "_xor"},   64'(bus.out_xor),   64'(2'b00));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = 2'b00;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed words: 1001, x111, z001, x000
    send_word(2'b01, 2'b00, 2'b00, 2'b01);
    cycle(1'b0, 2'b00, 1'b1);
    send_word(2'b10, 2'b01, 2'b01, 2'b01);
    cycle(1'b0, 2'b00, 1'b1);
    send_word(2'b11, 2'b00, 2'b00, 2'b01);
    cycle(1'b0, 2'b00, 1'b1);
    send_word(2'b10, 2'b00, 2'b00, 2'b00);
    cycle(1'b0, 2'b00, 1'b1);

    // back-to-back words with no bubble
    send_word(2'b01, 2'b00, 2'b00, 2'b01);
    send_word(2'b00, 2'b00, 2'b00, 2'b00);
    cycle(1'b0, 2'b00, 1'b1);

    // stall with a full word, then release with a symbol pending
    send_word(2'b01, 2'b01, 2'b10, 2'b00);
    repeat (3) cycle(1'b1, 2'b01, 1'b0);
    cycle(1'b1, 2'b01, 1'b1);
    cycle(1'b1, 2'b11, 1'b1);
    cycle(1'b1, 2'b01, 1'b1);
    cycle(1'b1, 2'b01, 1'b1);
    cycle(1'b0, 2'b00, 1'b1);

    // reset mid-word discards the partial word
    cycle(1'b1, 2'b00, 1'b1);
    cycle(1'b1, 2'b10, 1'b1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    chk("midrst_hold_valid", 64'(bus.out_valid), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    send_word(2'b01, 2'b01, 2'b01, 2'b01);
    cycle(1'b0, 2'b00, 1'b1);

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom),
            1'($urandom_range(0, 2) != 0));
    end
    cycle(1'b0, 2'b00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

endmodule
